// File: rtl/parity_uart_tx_ctrl.sv
// Frame sequencer for the 9-bit parity path: accepts a byte, forms even/odd
// parity and serialises start, 8 data bits (LSB first), parity and stop bits.
module parity_uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    input  logic       odd_sel_i,
    output logic       tx_ready_o,
    output logic       tx_line_o,
    output logic       busy_o,
    output logic       parity_bit_o,
    output logic       frame_done_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic            tx_line_q, tx_line_d;
    logic            bit_wrap;
    logic            done;

    assign bit_wrap = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));

    // Next-state logic: bit timing, data shifting and parity capture.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (tx_valid_i) begin
                    shift_d  = tx_data_i;
                    // Even mode makes the 9-bit ones count even, odd mode makes it odd.
                    parity_d = (^tx_data_i) ^ odd_sel_i;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_wrap) begin
                    clk_cnt_d = '0;
                    state_d   = StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_wrap) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = StParity;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StParity: begin
                if (bit_wrap) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = StStop;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_wrap) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        done      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level is derived from the next state so the pin is registered
    // and the start bit appears in the cycle right after the accept edge.
    always_comb begin
        tx_line_d = 1'b1;
        unique case (state_d)
            StIdle:   tx_line_d = 1'b1;
            StStart:  tx_line_d = 1'b0;
            StData:   tx_line_d = shift_d[0];
            StParity: tx_line_d = parity_d;
            StStop:   tx_line_d = 1'b1;
            default:  tx_line_d = 1'b1;
        endcase
    end

    // State, counters, shift register, parity and line registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_line_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_line_q <= tx_line_d;
        end
    end

    assign tx_ready_o   = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign tx_line_o    = tx_line_q;
    assign parity_bit_o = parity_q;
    assign frame_done_o = done;

endmodule

// File: tb/tb_parity_uart_tx_ctrl.sv
// Bench for parity_uart_tx_ctrl: three instances with different bit timing,
// a frame-level reference model, a per-cycle compare and directed vectors.
module tb_parity_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i [3];
    logic [2:0] valid;
    logic [2:0] odd_i;
    logic [2:0] ready;
    logic [2:0] line;
    logic [2:0] busy;
    logic [2:0] par;
    logic [2:0] done;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    parity_uart_tx_ctrl #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(data_i[0]), .tx_valid_i(valid[0]),
        .odd_sel_i(odd_i[0]), .tx_ready_o(ready[0]), .tx_line_o(line[0]), .busy_o(busy[0]),
        .parity_bit_o(par[0]), .frame_done_o(done[0])
    );
    parity_uart_tx_ctrl #(.CLKS_PER_BIT(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(data_i[1]), .tx_valid_i(valid[1]),
        .odd_sel_i(odd_i[1]), .tx_ready_o(ready[1]), .tx_line_o(line[1]), .busy_o(busy[1]),
        .parity_bit_o(par[1]), .frame_done_o(done[1])
    );
    parity_uart_tx_ctrl #(.CLKS_PER_BIT(16), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(data_i[2]), .tx_valid_i(valid[2]),
        .odd_sel_i(odd_i[2]), .tx_ready_o(ready[2]), .tx_line_o(line[2]), .busy_o(busy[2]),
        .parity_bit_o(par[2]), .frame_done_o(done[2])
    );

    function automatic int cpb(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    function automatic int sbits(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    // Line level in frame cycle k (k = 1 is the first cycle after the accept edge).
    function automatic logic exp_line(input int k, input int c, input logic [7:0] b,
                                      input logic p);
        int idx;
        idx = (k - 1) / c;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9) return p;
        return 1'b1;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Reference model: one frame is a run of (10+STOP_BITS)*CLKS_PER_BIT cycles.
    bit         m_act  [3];
    int         m_k    [3];
    logic [7:0] m_data [3];
    logic       m_par  [3];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_act[d] <= 1'b0;
                m_k[d]   <= 0;
                m_par[d] <= 1'b0;
            end else if (m_act[d]) begin
                if (m_k[d] == (10 + sbits(d)) * cpb(d)) m_act[d] <= 1'b0;
                else m_k[d] <= m_k[d] + 1;
            end else if (valid[d]) begin
                m_act[d]  <= 1'b1;
                m_k[d]    <= 1;
                m_data[d] <= data_i[d];
                m_par[d]  <= odd_i[d] ? ($countones(data_i[d]) % 2 == 0)
                                      : ($countones(data_i[d]) % 2 == 1);
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            check("tx_ready", d, 32'(ready[d]), 32'(!m_act[d]));
            check("busy", d, 32'(busy[d]), 32'(m_act[d]));
            check("parity_bit", d, 32'(par[d]), 32'(m_par[d]));
            check("tx_line", d, 32'(line[d]),
                  32'(m_act[d] ? exp_line(m_k[d], cpb(d), m_data[d], m_par[d]) : 1'b1));
            check("frame_done", d, 32'(done[d]),
                  32'(m_act[d] && (m_k[d] == (10 + sbits(d)) * cpb(d))));
        end
    end

    logic [10:0] a5_line;

    // Accept one byte, scramble inputs while busy, and pin literal expectations.
    task automatic run_frame(input int d, input logic [7:0] b, input logic odd,
                             input logic exp_par, input int exp_len, input bit pin_a5);
        int first;
        first = 0;
        @(negedge clk);
        data_i[d] = b;
        odd_i[d]  = odd;
        valid[d]  = 1'b1;
        @(negedge clk);
        check("busy_after_accept", d, 32'(busy[d]), 32'd1);
        check("parity_literal", d, 32'(par[d]), 32'(exp_par));
        data_i[d] = ~b;
        odd_i[d]  = ~odd;
        for (int k = 1; k <= exp_len + 2; k++) begin
            if (done[d] && first == 0) first = k;
            if (pin_a5 && k <= 44 && ((k - 1) % 4) == 1)
                check("a5_midbit", d, 32'(line[d]), 32'(a5_line[(k-1)/4]));
            if (k == exp_len - 1) valid[d] = 1'b0;
            @(negedge clk);
        end
        check("frame_done_cycle", d, 32'(first), 32'(exp_len));
        check("parity_hold", d, 32'(par[d]), 32'(exp_par));
    endtask

    initial begin
        int first;
        // Expected mid-bit line samples for 8'hA5 even: start, LSB..MSB, parity, stop.
        a5_line = 11'b101_0100_1010;
        for (int d = 0; d < 3; d++) data_i[d] = 8'h00;
        valid = '0;
        odd_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_line", 0, 32'(line[0]), 32'd1);
        check("reset_ready", 0, 32'(ready[0]), 32'd1);
        check("reset_busy", 0, 32'(busy[0]), 32'd0);
        check("reset_done", 0, 32'(done[0]), 32'd0);
        check("reset_parity", 0, 32'(par[0]), 32'd0);
        repeat (10) @(negedge clk);

        run_frame(0, 8'hA5, 1'b0, 1'b0, 44, 1'b1);
        run_frame(0, 8'h07, 1'b1, 1'b0, 44, 1'b0);
        run_frame(0, 8'h00, 1'b1, 1'b1, 44, 1'b0);
        run_frame(0, 8'h07, 1'b0, 1'b1, 44, 1'b0);
        run_frame(1, 8'hA5, 1'b1, 1'b1, 12, 1'b0);
        run_frame(2, 8'h80, 1'b0, 1'b1, 176, 1'b0);

        // Back-to-back with tx_valid held high across both frames.
        @(negedge clk);
        data_i[0] = 8'h3C;
        odd_i[0]  = 1'b0;
        valid[0]  = 1'b1;
        @(negedge clk);
        first = 0;
        for (int k = 1; k <= 95; k++) begin
            if (k == 2) begin
                data_i[0] = 8'hC3;
                odd_i[0]  = 1'b1;
            end
            if (done[0] && first == 0) first = k;
            if (k == 45) begin
                check("b2b_gap_ready", 0, 32'(ready[0]), 32'd1);
                check("b2b_gap_line", 0, 32'(line[0]), 32'd1);
            end
            if (k == 46) begin
                check("b2b_second_busy", 0, 32'(busy[0]), 32'd1);
                check("b2b_second_start", 0, 32'(line[0]), 32'd0);
                check("b2b_second_parity", 0, 32'(par[0]), 32'd1);
                valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_first_done", 0, 32'(first), 32'd44);

        // Reset during DATA bit 3 of an 8'hF0 frame.
        @(negedge clk);
        data_i[0] = 8'hF0;
        odd_i[0]  = 1'b0;
        valid[0]  = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_line", 0, 32'(line[0]), 32'd1);
        check("midreset_busy", 0, 32'(busy[0]), 32'd0);
        check("midreset_done", 0, 32'(done[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(0, 8'h97, 1'b0, 1'b1, 44, 1'b0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/parity_uart_tx_ctrl.md
Name: parity_uart_tx_ctrl

Overview:
Frame sequencer for the 9-bit parity path. Accepts an 8-bit byte over a valid/ready handshake and forms the 9-bit word {parity, data} using the same even/odd parity function as the HC280 generator. It then serialises that word onto a single line as start, data (LSB first), parity and stop bits, each held for a programmable number of clocks. It sits between a byte producer and the serial pin, and owns all bit timing.

Parameters:
CLKS_PER_BIT, 4, clock cycles each line bit is held; legal range is 1 or more.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
tx_data  input  8  byte to send; sampled only on an accept.
tx_valid  input  1  producer has a byte.
odd_sel  input  1  parity mode, sampled on an accept: 0 = even, 1 = odd.
tx_ready  output  1  block can accept a byte; high only in IDLE.
tx_line  output  1  serial output; idles high.
busy  output  1  high in every state except IDLE.
parity_bit  output  1  parity bit of the current or most recent frame (registered).
frame_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - state = IDLE, tx_line = 1, tx_ready = 1, busy = 0, parity_bit = 0, frame_done = 0.
  - Bit and clock counters clear to 0.
  - A frame in progress is aborted with no completion pulse.
- Accept: tx_valid & tx_ready at a rising edge.
  - On that edge, latch tx_data into the shift register.
  - parity_bit = ^tx_data when odd_sel = 0 (total ones in the 9-bit word is even).
  - parity_bit = ~^tx_data when odd_sel = 1 (total ones is odd).
  - State moves to START. tx_ready falls and busy rises in the following cycle.
- States (each line bit lasts exactly CLKS_PER_BIT cycles; a clock counter counts 0..CLKS_PER_BIT-1):
  - IDLE: tx_line = 1.
  - START: tx_line = 0. Goes to DATA when the count wraps.
  - DATA: tx_line = shift_reg[0]. Shift right on each wrap; bit index 0..7. Goes to PARITY after index 7 wraps.
  - PARITY: tx_line = parity_bit. Goes to STOP.
  - STOP: tx_line = 1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done is asserted on the last of those cycles, and the next state is IDLE.
- Timing:
  - tx_line is registered. The first start-bit cycle is the cycle after the accept edge.
  - Frame length is (10+STOP_BITS)*CLKS_PER_BIT cycles; the default is 44.
- Back-to-back: tx_ready is high in the cycle after frame_done. A held tx_valid is accepted on that edge, so the gap between frames is one idle-high cycle.
- Inputs outside an accept:
  - tx_valid while busy is ignored and the byte is not captured.
  - tx_data and odd_sel changes mid-frame have no effect.
- parity_bit holds its value after the frame ends until the next accept.
- CLKS_PER_BIT = 1: every state lasts one cycle and the frame is 11 cycles with STOP_BITS = 1.
- No X on any output after reset, for any input pattern.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles, then release -> tx_line = 1, tx_ready = 1, busy = 0, frame_done = 0; values hold for 10 idle cycles.
- Even frame: send tx_data = 8'hA5, odd_sel = 0 -> parity_bit = 0. Sampling tx_line mid-bit gives 0,1,0,1,0,0,1,0,1,0,1. frame_done pulses exactly 44 cycles after the accept edge.
- Odd mode: send 8'h07, odd_sel = 1 -> parity_bit = 0. Send 8'h00, odd_sel = 1 -> parity_bit = 1. Send 8'h07, odd_sel = 0 -> parity_bit = 1.
- Back-to-back: hold tx_valid high with 8'h3C then 8'hC3 -> second accept lands on the cycle after frame_done, with one idle-high cycle between frames. Bytes issued while busy are never captured.
- Reset mid-frame: pull rst_n low during DATA bit 3 -> tx_line = 1 immediately, with no frame_done pulse. A new byte after release produces a complete, correct frame.
- Parameter sweep: CLKS_PER_BIT = 1 with STOP_BITS = 2 gives a 12-cycle frame. CLKS_PER_BIT = 16 with STOP_BITS = 1 gives a 176-cycle frame. Parity is correct in both.
